// File: rtl/float_to_fixed_pkg.sv
// float_to_fixed_pkg: shared defaults, float field layout and input class
// encoding for the float_to_fixed converter.
package float_to_fixed_pkg;

    localparam int DEF_FIXED_WIDTH = 12;
    localparam int DEF_FRAC_WIDTH  = 0;
    localparam int DEF_EXP_WIDTH   = 8;
    localparam int DEF_MANT_WIDTH  = 23;
    localparam int DEF_BIAS        = (1 << (DEF_EXP_WIDTH - 1)) - 1;

    // Field view of a float at the default widths
    typedef struct packed {
        logic                      sign;
        logic [DEF_EXP_WIDTH-1:0]  exp;
        logic [DEF_MANT_WIDTH-1:0] mant;
    } float_t;

    // Input class; denormals fold into CLS_ZERO since both flush to 0
    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_e;

endpackage

// File: rtl/float_to_fixed_align.sv
// float_to_fixed_align: combinational barrel shifter. Scales the mantissa
// (hidden bit included) by 2^sh and returns the integer magnitude, the
// half-LSB guard bit and the OR of everything below it (sticky).
// Only meaningful for sh in [-MANT_WIDTH-1, FIXED_WIDTH-1-MANT_WIDTH]; the
// caller routes anything outside that window to the zero/saturate paths.
module float_to_fixed_align
    import float_to_fixed_pkg::*;
#(
    parameter int FIXED_WIDTH = DEF_FIXED_WIDTH,
    parameter int MANT_WIDTH  = DEF_MANT_WIDTH
) (
    input  logic [MANT_WIDTH:0]    mant,
    input  logic signed [31:0]     sh,
    output logic [FIXED_WIDTH-1:0] mag,
    output logic                   guard,
    output logic                   sticky
);

    // Mantissa is parked FIXED_WIDTH+1 bits up so a single right shift
    // covers both the left- and right-shift cases of sh.
    localparam int XW = MANT_WIDTH + FIXED_WIDTH + 2;

    logic [XW-1:0] x;
    logic [XW-1:0] y;
    int            rs;
    logic          unused_hi;

    // Right-shift the parked mantissa; bits that fall off feed sticky
    always_comb begin
        x      = {mant, {(FIXED_WIDTH + 1){1'b0}}};
        rs     = FIXED_WIDTH - sh;
        y      = x >> rs;
        mag    = y[FIXED_WIDTH:1];
        guard  = y[0];
        sticky = ((y << rs) != x);
    end

    // Above-range bits are always zero inside the legal shift window
    assign unused_hi = |y[XW-1:FIXED_WIDTH+1];

endmodule

// File: rtl/float_to_fixed.sv
// float_to_fixed: IEEE-754 float to signed fixed-point, 3-stage pipeline
// (unpack/classify, align, sign/saturate) with a common clock enable.
// Define FLOAT_TO_FIXED_ROUND_EN for round-to-nearest, ties away from zero;
// otherwise the result truncates toward zero.
module float_to_fixed
    import float_to_fixed_pkg::*;
#(
    parameter int FIXED_WIDTH = DEF_FIXED_WIDTH,
    parameter int FRAC_WIDTH  = DEF_FRAC_WIDTH,
    parameter int EXP_WIDTH   = DEF_EXP_WIDTH,
    parameter int MANT_WIDTH  = DEF_MANT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   a,
    output logic [FIXED_WIDTH-1:0]          q
);

    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam logic [FIXED_WIDTH-1:0] Q_MAX = {1'b0, {(FIXED_WIDTH - 1){1'b1}}};
    localparam logic [FIXED_WIDTH-1:0] Q_MIN = {1'b1, {(FIXED_WIDTH - 1){1'b0}}};
    localparam logic [FIXED_WIDTH:0]   HALF  = {2'b01, {(FIXED_WIDTH - 1){1'b0}}};

    typedef struct packed {
        logic                    sign;
        logic [EXP_WIDTH+1:0]    e;      // unbiased exponent, two's complement
        logic [MANT_WIDTH:0]     mant;   // hidden bit included
        cls_e                    cls;
        logic                    ovf;    // magnitude certainly >= 2^FIXED_WIDTH
        logic                    under;  // magnitude certainly < 0.5 LSB
    } s1_t;

    typedef struct packed {
        logic                    sign;
        logic                    sat;
        logic [FIXED_WIDTH-1:0]  mag;
        logic                    guard;
        logic                    sticky;
    } s2_t;

    s1_t s1_d, s1_r;
    s2_t s2_d, s2_r;

    logic [EXP_WIDTH-1:0]  a_exp;
    logic [MANT_WIDTH-1:0] a_mant;
    int                    p_d;

    assign a_exp  = a[EXP_WIDTH+MANT_WIDTH-1 -: EXP_WIDTH];
    assign a_mant = a[MANT_WIDTH-1:0];

    // Stage 1: unpack fields and classify. p_d is the power of two of the
    // leading mantissa bit in output-LSB units; p_d >= FIXED_WIDTH can never
    // fit, so it bypasses the shifter entirely.
    always_comb begin
        s1_d       = '0;
        p_d        = int'(a_exp) - BIAS + FRAC_WIDTH;
        s1_d.sign  = a[EXP_WIDTH+MANT_WIDTH];
        s1_d.e     = (EXP_WIDTH + 2)'(int'(a_exp) - BIAS);
        s1_d.mant  = {1'b1, a_mant};
        if (a_exp == '1)
            s1_d.cls = (a_mant != '0) ? CLS_NAN : CLS_INF;
        else if (a_exp == '0)
            s1_d.cls = CLS_ZERO;
        else
            s1_d.cls = CLS_NORM;
        s1_d.ovf   = (p_d >= FIXED_WIDTH);
        s1_d.under = (p_d < -1);
    end

    logic signed [31:0]     sh;
    logic [FIXED_WIDTH-1:0] al_mag;
    logic                   al_guard;
    logic                   al_sticky;

    assign sh = 32'($signed(s1_r.e)) + FRAC_WIDTH - MANT_WIDTH;

    float_to_fixed_align #(
        .FIXED_WIDTH (FIXED_WIDTH),
        .MANT_WIDTH  (MANT_WIDTH)
    ) u_align (
        .mant   (s1_r.mant),
        .sh     (sh),
        .mag    (al_mag),
        .guard  (al_guard),
        .sticky (al_sticky)
    );

    // Stage 2: pick shifter result, or force the zero / saturate outcome
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_r.sign;
        unique case (s1_r.cls)
            CLS_INF:  s2_d.sat = 1'b1;
            CLS_NORM: begin
                if (s1_r.ovf) begin
                    s2_d.sat = 1'b1;
                end else if (!s1_r.under) begin
                    s2_d.mag    = al_mag;
                    s2_d.guard  = al_guard;
                    s2_d.sticky = al_sticky;
                end
            end
            default: ;  // zero, denormal, NaN: magnitude stays 0
        endcase
    end

    logic [FIXED_WIDTH:0]   rmag;
    logic [FIXED_WIDTH-1:0] q_d;
    logic                   unused_rnd;

    // Ties go away from zero, so the guard bit alone decides the increment;
    // sticky only separates an exact tie from above-half, which round alike.
    assign unused_rnd = s2_r.sticky ^ s2_r.guard;

    // Stage 3: optional rounding, then apply sign and clamp
    always_comb begin
        q_d = '0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        rmag = {1'b0, s2_r.mag} + {{FIXED_WIDTH{1'b0}}, s2_r.guard};
`else
        rmag = {1'b0, s2_r.mag};
`endif
        if (s2_r.sat)
            q_d = s2_r.sign ? Q_MIN : Q_MAX;
        else if (s2_r.sign)
            q_d = (rmag > HALF) ? Q_MIN : (~rmag[FIXED_WIDTH-1:0] + FIXED_WIDTH'(1));
        else
            q_d = (rmag >= HALF) ? Q_MAX : rmag[FIXED_WIDTH-1:0];
    end

    // Pipeline registers: reset flushes everything, en=0 stalls all stages
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
            q    <= '0;
        end else if (en) begin
            s1_r <= s1_d;
            s2_r <= s2_d;
            q    <= q_d;
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed and randomized checks of float_to_fixed at
// default parameters against a real-arithmetic reference model.
module tb_float_to_fixed;
    import float_to_fixed_pkg::*;

    localparam int W = 12;
    localparam int FRAC = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [11:0] q;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected value at each pipeline depth; [2] is what q must show
    logic [11:0] pipe [3];

    always #5 clk = ~clk;

    float_to_fixed dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .q   (q)
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%03h expected %03h", tag, got, exp);
        end
    endtask

    // Reference: evaluate the float as a real number, scale, round, clamp
    function automatic logic [11:0] ref_q(input logic [31:0] v);
        float_t f;
        real    m;
        real    s;
        int     e;
        int     n;
        f = v;
        if (f.exp == 8'hFF)
            return (f.mant != 0) ? 12'h000 : (f.sign ? 12'h800 : 12'h7FF);
        if (f.exp == 8'h00)
            return 12'h000;
        s = 1.0;
        e = int'(f.exp) - 127 + FRAC;
        for (int k = 0; k < e; k++) s = s * 2.0;
        for (int k = 0; k > e; k--) s = s / 2.0;
        m = (1.0 + real'(f.mant) / 8388608.0) * s;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        m = m + 0.5;
`endif
        n = (m >= 1.0e6) ? 1000000 : $rtoi(m);
        if (f.sign)
            return (n > (1 << (W - 1))) ? 12'h800 : 12'(-n);
        return (n >= (1 << (W - 1))) ? 12'h7FF : 12'(n);
    endfunction

    // One clock: drive, advance the model, check q just after the edge
    task automatic cycle(input logic e, input logic [31:0] v, input string tag);
        en = e;
        a  = v;
        @(posedge clk);
        if (rst) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        end else if (e) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = ref_q(v);
        end
        #1;
        chk(tag, q, pipe[2]);
    endtask

    // Push one value, drain it to q, and check a hand-derived constant
    task automatic directed(input string tag, input logic [31:0] v, input logic [11:0] expq);
        cycle(1'b1, v, tag);
        cycle(1'b1, 32'h0, tag);
        cycle(1'b1, 32'h0, tag);
        chk({tag, "_const"}, q, expq);
    endtask

    logic [31:0] rv;
    int          mode;

    initial begin
        rst = 1'b1; en = 1'b0; a = '0;
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        cycle(1'b0, 32'h0, "reset");
        cycle(1'b1, 32'h3F800000, "reset_en");   // reset beats en
        chk("reset_q", q, 12'h000);
        rst = 1'b0;

        directed("zero",      32'h00000000, 12'h000);
        directed("one",       32'h3F800000, 12'h001);
        directed("min_exact", 32'hC5000000, 12'h800);
        directed("max_exact", 32'h44FFE000, 12'h7FF);
        directed("sat_pos",   32'h45000000, 12'h7FF);
        directed("sat_neg",   32'hC5001000, 12'h800);
        directed("pinf",      32'h7F800000, 12'h7FF);
        directed("ninf",      32'hFF800000, 12'h800);
        directed("qnan",      32'h7FC00000, 12'h000);
        directed("nnan",      32'hFFC00000, 12'h000);
        directed("denorm",    32'h00400000, 12'h000);
        directed("negzero",   32'h80000000, 12'h000);
        directed("quarter",   32'h3E800000, 12'h000);
        directed("p2047_5",   32'h44FFF000, 12'h7FF);
`ifdef FLOAT_TO_FIXED_ROUND_EN
        directed("m1_5",      32'hBFC00000, 12'hFFE);
        directed("p0_75",     32'h3F400000, 12'h001);
        directed("p0_5",      32'h3F000000, 12'h001);
        directed("m0_5",      32'hBF000000, 12'hFFF);
        directed("m2047_5",   32'hC4FFF000, 12'h800);
`else
        directed("m1_5",      32'hBFC00000, 12'hFFF);
        directed("p0_75",     32'h3F400000, 12'h000);
        directed("p0_5",      32'h3F000000, 12'h000);
        directed("m0_5",      32'hBF000000, 12'h000);
        directed("m2047_5",   32'hC4FFF000, 12'h801);
`endif

        // Stall mid-stream: q holds, then 1, 2, 3 emerge in order
        cycle(1'b1, 32'h3F800000, "stall");
        cycle(1'b1, 32'h40000000, "stall");
        cycle(1'b0, 32'h45000000, "stall_hold");
        cycle(1'b0, 32'hC5001000, "stall_hold");
        cycle(1'b1, 32'h40400000, "stall");
        chk("stream_1", q, 12'h001);
        cycle(1'b1, 32'h0, "stall");
        chk("stream_2", q, 12'h002);
        cycle(1'b1, 32'h0, "stall");
        chk("stream_3", q, 12'h003);

        // Reset mid-stream discards in-flight data
        cycle(1'b1, 32'h40000000, "rst_mid");
        cycle(1'b1, 32'h40400000, "rst_mid");
        rst = 1'b1;
        cycle(1'b0, 32'h40800000, "rst_mid");
        rst = 1'b0;
        cycle(1'b1, 32'h0, "rst_mid");
        cycle(1'b1, 32'h0, "rst_mid");
        chk("rst_flush", q, 12'h000);

        // Random traffic with random stalls and rare resets
        for (int i = 0; i < 600; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: rv = $urandom;
                3: begin
                    case ($urandom_range(0, 3))
                        0: rv = {1'($urandom), 8'hFF, 23'($urandom)};
                        1: rv = {1'($urandom), 8'h00, 23'($urandom)};
                        2: rv = {1'($urandom), 8'd138, 23'($urandom_range(0, 3) << 11)};
                        default: rv = {1'($urandom), 8'($urandom_range(140, 254)), 23'($urandom)};
                    endcase
                end
                default: rv = {1'($urandom), 8'($urandom_range(124, 139)), 23'($urandom)};
            endcase
            rst = ($urandom_range(0, 79) == 0);
            cycle($urandom_range(0, 3) != 0, rv, "rand");
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
